// File: rtl/pararam_pkg.sv
// rtl/pararam_pkg.sv - shared constants and types for the ParaRAM port arbiter
package pararam_pkg;

    localparam int PARARAM_ADDR_WIDTH = 9;
    localparam int PARARAM_DATA_WIDTH = 16;
    localparam int MEM_WORDS          = 1 << PARARAM_ADDR_WIDTH;
    localparam int RD_LATENCY         = 2;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

endpackage

// File: rtl/pararam_rr_grant.sv
// rtl/pararam_rr_grant.sv - stateless round-robin search, first request after ptr wins
module pararam_rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Offsets 1..NUM_REQ visit every requester once, ending on ptr itself.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pararam_arbiter.sv
// rtl/pararam_arbiter.sv - round-robin sharing of the single-port ParaRAM between requesters
module pararam_arbiter
    import pararam_pkg::*;
#(
    parameter int ADDR_WIDTH = PARARAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = PARARAM_DATA_WIDTH,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_wc,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    accept;
    logic                  any_acc;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [NUM_REQ-1:0]    rd_tag;

    pararam_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_grant (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready is forced low while reset is held so nothing looks accepted upstream.
    assign req_ready = grant & {NUM_REQ{arb_en & ~rst}};
    assign accept    = req_valid & req_ready;
    assign any_acc   = |accept;

    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx   = PTR_W'(i);
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // rd_tag travels with the registered command; rsp_valid lines up with RAM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= PTR_W'(NUM_REQ - 1);
            mem_en    <= 1'b0;
            mem_wc    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_tag    <= '0;
            rsp_valid <= '0;
        end else begin
            mem_en    <= any_acc;
            rd_tag    <= accept & {NUM_REQ{win_we == CMD_READ}};
            rsp_valid <= rd_tag;
            if (any_acc) begin
                ptr       <= win_idx;
                mem_wc    <= win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end
        end
    end

    assign rsp_rdata = mem_rdata;
    assign busy      = mem_en | (|rsp_valid) | (|rd_tag);

endmodule

// File: tb/tb_pararam_arbiter.sv
// tb/tb_pararam_arbiter.sv - scoreboard bench for pararam_arbiter with a behavioral RAM
module tb_pararam_arbiter;

    localparam int NR = 4;
    localparam int AW = 9;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            arb_en = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_wc;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;

    pararam_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_wc    (mem_wc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [NR-1:0] idx;
        logic [DW-1:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] a_r[NR];
    logic [DW-1:0] d_r[NR];
    logic [DW-1:0] shadow[int];
    logic [DW-1:0] ram[512];
    bit            ram_wr[512];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {7'h2D, a} ^ 16'h0F0F;
    endfunction

    // Behavioral single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wc) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests; exp_ready is the hand-computed winner.
    task automatic drive(input logic en, input logic [NR-1:0] v, input logic [NR-1:0] we,
                         input logic [NR-1:0] exp_ready, input bit push, input string name);
        cmd_t c;
        rsp_t r;
        @(posedge clk);
        #1;
        arb_en    = en;
        req_valid = v;
        req_we    = we;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = a_r[i];
            req_wdata[i*DW +: DW] = d_r[i];
        end
        #3;
        chk(name, 32'(req_ready), 32'(exp_ready));
        if (push) begin
            for (int i = 0; i < NR; i++) begin
                if (exp_ready[i]) begin
                    c.we = we[i]; c.addr = a_r[i]; c.wdata = d_r[i];
                    cmd_q.push_back(c);
                    if (we[i]) begin
                        shadow[int'(a_r[i])] = d_r[i];
                    end else begin
                        r.idx  = exp_ready;
                        r.data = shadow.exists(int'(a_r[i])) ? shadow[int'(a_r[i])] : init_val(a_r[i]);
                        rsp_q.push_back(r);
                    end
                end
            end
        end
    endtask

    // Monitor: every RAM command and every response strobe must match the scoreboard.
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (!rst) begin
            if (mem_en) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_mem_en", 32'(mem_en), 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    chk("mem_wc", 32'(mem_wc), 32'(c.we));
                    chk("mem_addr", 32'(mem_addr), 32'(c.addr));
                    if (c.we) chk("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(r.idx));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            a_r[i] = AW'(9'h010 + i);
            d_r[i] = 16'h0;
        end
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        req_valid = '0;
        rst = 1'b0;

        // Write from requester 0, then read it back through requester 2.
        a_r[0] = 9'h005; d_r[0] = 16'hBEEF;
        drive(1, 4'b0001, 4'b0001, 4'b0001, 1, "wr0_ready");
        drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");
        a_r[2] = 9'h005;
        drive(1, 4'b0100, 4'b0000, 4'b0100, 1, "rd2_ready");
        drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");
        repeat (2) drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");

        // Park ptr on requester 3, then all four read continuously for 8 cycles.
        a_r[2] = 9'h012;
        drive(1, 4'b1000, 4'b0000, 4'b1000, 1, "park3_ready");
        for (int k = 0; k < 8; k++)
            drive(1, 4'b1111, 4'b0000, 4'((1 << (k % 4))), 1, "rr_all_ready");
        drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");

        // ptr=1, then 1 and 3 contend: 3 (write) first, then 1 reads the new data.
        a_r[1] = 9'h011;
        drive(1, 4'b0010, 4'b0000, 4'b0010, 1, "set_ptr1_ready");
        a_r[1] = 9'h020; a_r[3] = 9'h020; d_r[3] = 16'h3333;
        drive(1, 4'b1010, 4'b1000, 4'b1000, 1, "pair_first3");
        drive(1, 4'b0010, 4'b0000, 4'b0010, 1, "pair_then1");

        // arb_en low for 3 cycles with everyone valid; ptr stays at 1.
        repeat (3) drive(0, 4'b1111, 4'b0000, 4'b0000, 1, "arb_off_ready");
        drive(1, 4'b1111, 4'b0000, 4'b0100, 1, "resume_2");
        drive(1, 4'b1111, 4'b0000, 4'b1000, 1, "resume_3");
        drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");
        repeat (3) drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");

        // Read accepted, then reset pulsed in the command cycle: no response may appear.
        a_r[0] = 9'h033;
        drive(1, 4'b0001, 4'b0000, 4'b0001, 0, "rst_rd_ready");
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("inflight_mem_en", 32'(mem_en), 32'd1);
        chk("inflight_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_mem_en", 32'(mem_en), 32'd0);
        chk("async_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        #1;
        rst = 1'b0;
        drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "post_rst_idle");
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        a_r[0] = 9'h012;
        drive(1, 4'b1111, 4'b0000, 4'b0001, 1, "post_rst_prio0");
        drive(1, 4'b0000, 4'b0000, 4'b0000, 1, "idle_ready");

        for (int w = 0; w < 20 && (cmd_q.size() != 0 || rsp_q.size() != 0); w++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
